rr_two_one_arbiter: RTL and testbench

- Two-requester round-robin arbiter with valid/ready handshakes on both inputs and the output.
- Sits directly upstream of, and wraps, the 2:1 mux datapath.
- Generates the mux select and steers the granted word into a one-entry registered output stage.
- Keeps saturating per-port grant counters for debug/statistics.

---
 rtl/rr_two_one_arbiter_pkg.sv | 14 +
 rtl/rr_two_one_arbiter_mux.sv | 11 +
 rtl/rr_two_one_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_two_one_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_two_one_arbiter_pkg.sv
// Shared constants and state encoding for the two-input round-robin arbiter.
package rr_two_one_arbiter_pkg;

    localparam logic PORT0          = 1'b0;
    localparam logic PORT1          = 1'b1;
    // Port 1 recorded as last winner so port 0 wins the first contention.
    localparam logic LAST_GRANT_RST = PORT1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_two_one_arbiter_mux.sv
// Single-bit 2:1 multiplexer; i_sel=0 passes i_a.
module two_one_mux (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/rr_two_one_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry registered output
// stage, with saturating per-port grant counters.
module rr_two_one_arbiter
    import rr_two_one_arbiter_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [DW-1:0]    in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [DW-1:0]    in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    out_state_t       r_state, w_state_nxt;
    logic             r_last_grant, w_last_grant_nxt;
    logic [DW-1:0]    r_out_data, w_out_data_nxt;
    logic             r_out_src, w_out_src_nxt;
    logic [CNT_W-1:0] r_cnt0, w_cnt0_nxt;
    logic [CNT_W-1:0] r_cnt1, w_cnt1_nxt;

    logic             w_grant;
    logic             w_can_load;
    logic             w_load;
    logic [DW-1:0]    w_mux_data;

    // Lone requester wins; on contention (or idle) alternate away from last winner.
    always_comb begin
        w_grant = ~r_last_grant;
        if (in0_valid && !in1_valid) begin
            w_grant = PORT0;
        end else if (in1_valid && !in0_valid) begin
            w_grant = PORT1;
        end
    end

    // No acceptance while reset is asserted, so nothing is handshaked and lost.
    assign w_can_load = rst_n & ((r_state == ST_EMPTY) | out_ready);
    assign in0_ready  = w_can_load & in0_valid & (w_grant == PORT0);
    assign in1_ready  = w_can_load & in1_valid & (w_grant == PORT1);
    assign w_load     = in0_ready | in1_ready;
    assign sel        = w_grant;

    genvar g;
    generate
        for (g = 0; g < int'(DW); g++) begin : g_mux
            two_one_mux u_mux (
                .i_a   (in0_data[g]),
                .i_b   (in1_data[g]),
                .i_sel (w_grant),
                .o_y   (w_mux_data[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_last_grant <= LAST_GRANT_RST;
            r_out_data   <= '0;
            r_out_src    <= PORT0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_src    <= w_out_src_nxt;
            r_cnt0       <= w_cnt0_nxt;
            r_cnt1       <= w_cnt1_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_out_data_nxt   = r_out_data;
        w_out_src_nxt    = r_out_src;
        w_cnt0_nxt       = r_cnt0;
        w_cnt1_nxt       = r_cnt1;

        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !w_load) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase

        if (w_load) begin
            w_out_data_nxt   = w_mux_data;
            w_out_src_nxt    = w_grant;
            w_last_grant_nxt = w_grant;
        end

        // Clear wins over a same-cycle increment; counters stick at all-ones.
        if (clr_cnt) begin
            w_cnt0_nxt = '0;
            w_cnt1_nxt = '0;
        end else begin
            if (in0_ready && (r_cnt0 != CNT_MAX)) begin
                w_cnt0_nxt = r_cnt0 + CNT_W'(1);
            end
            if (in1_ready && (r_cnt1 != CNT_MAX)) begin
                w_cnt1_nxt = r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

endmodule

// File: tb/tb_rr_two_one_arbiter.sv
// Directed self-checking bench for rr_two_one_arbiter (default widths plus a
// narrow-counter instance for saturation).
`timescale 1ns/1ps
module tb_rr_two_one_arbiter;

    logic       clk;
    logic       rst_n;
    logic       in0_valid, in1_valid, out_ready, clr_cnt;
    logic [7:0] in0_data, in1_data;
    logic       in0_ready, in1_ready, out_valid, out_src, sel;
    logic [7:0] out_data, cnt0, cnt1;

    logic       b_rst_n;
    logic       b_in0_valid, b_in1_valid, b_out_ready, b_clr_cnt;
    logic [7:0] b_in0_data, b_in1_data;
    logic       b_in0_ready, b_in1_ready, b_out_valid, b_out_src, b_sel;
    logic [7:0] b_out_data;
    logic [1:0] b_cnt0, b_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_two_one_arbiter #(.DW(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .sel(sel), .clr_cnt(clr_cnt),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    rr_two_one_arbiter #(.DW(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(b_rst_n),
        .in0_valid(b_in0_valid), .in0_data(b_in0_data), .in0_ready(b_in0_ready),
        .in1_valid(b_in1_valid), .in1_data(b_in1_data), .in1_ready(b_in1_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_src(b_out_src),
        .out_ready(b_out_ready), .sel(b_sel), .clr_cnt(b_clr_cnt),
        .cnt0(b_cnt0), .cnt1(b_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_data [4];
    logic       exp_src  [4];

    initial begin
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h11; exp_data[3] = 8'h22;
        exp_src[0]  = 1'b0;  exp_src[1]  = 1'b1;  exp_src[2]  = 1'b0;  exp_src[3]  = 1'b1;

        rst_n     = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h11;
        in1_valid = 1'b1; in1_data = 8'h22;
        out_ready = 1'b1; clr_cnt  = 1'b0;
        b_rst_n     = 1'b0;
        b_in0_valid = 1'b0; b_in0_data = 8'h00;
        b_in1_valid = 1'b0; b_in1_data = 8'h00;
        b_out_ready = 1'b1; b_clr_cnt  = 1'b0;

        // Reset held with both requests up.
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        check("rst_in0_ready", 32'(in0_ready), 32'd0);
        check("rst_in1_ready", 32'(in1_ready), 32'd0);
        tick();
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_sel", 32'(sel), 32'd0);
        check("post_rst_in0_ready", 32'(in0_ready), 32'd1);
        check("post_rst_in1_ready", 32'(in1_ready), 32'd0);

        // Alternating contention, one word per cycle.
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("alt_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("alt_data_%0d", i), 32'(out_data), 32'(exp_data[i]));
            check($sformatf("alt_src_%0d", i), 32'(out_src), 32'(exp_src[i]));
        end
        check("alt_cnt0", 32'(cnt0), 32'd2);
        check("alt_cnt1", 32'(cnt1), 32'd2);

        // Downstream stall holding 0x22.
        out_ready = 1'b0;
        #1;
        check("stall_in0_ready", 32'(in0_ready), 32'd0);
        check("stall_in1_ready", 32'(in1_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_data_%0d", i), 32'(out_data), 32'h22);
            check($sformatf("stall_src_%0d", i), 32'(out_src), 32'd1);
            check($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("stall_rdy_%0d", i), 32'({in0_ready, in1_ready}), 32'd0);
        end
        check("stall_cnt1", 32'(cnt1), 32'd2);
        out_ready = 1'b1;
        #1;
        check("unstall_sel", 32'(sel), 32'd0);
        check("unstall_in0_ready", 32'(in0_ready), 32'd1);
        tick();
        check("unstall_data", 32'(out_data), 32'h11);
        check("unstall_src", 32'(out_src), 32'd0);
        check("unstall_cnt0", 32'(cnt0), 32'd3);

        // Port 1 alone for five beats.
        in0_valid = 1'b0;
        in1_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in1_data = 8'(k);
            #1;
            check($sformatf("p1_ready_%0d", k), 32'(in1_ready), 32'd1);
            tick();
            check($sformatf("p1_data_%0d", k), 32'(out_data), 32'(k));
            check($sformatf("p1_src_%0d", k), 32'(out_src), 32'd1);
        end
        check("p1_cnt1", 32'(cnt1), 32'd7);
        check("p1_cnt0", 32'(cnt0), 32'd3);
        in1_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_cnt1", 32'(cnt1), 32'd7);

        // Async reset discards a held word.
        in0_valid = 1'b1;
        in0_data  = 8'h5A;
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'h5A);
        in0_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_cnt0", 32'(cnt0), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h33;
        in1_valid = 1'b1; in1_data = 8'h44;
        out_ready = 1'b1;
        #1;
        check("rerst_sel", 32'(sel), 32'd0);
        check("rerst_in0_ready", 32'(in0_ready), 32'd1);
        tick();
        check("rerst_data", 32'(out_data), 32'h33);
        check("rerst_src", 32'(out_src), 32'd0);

        // Narrow counter: saturation then clear beating a same-cycle increment.
        @(negedge clk);
        b_rst_n     = 1'b1;
        b_in0_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            b_in0_data = 8'(k);
            tick();
            check($sformatf("sat_cnt0_%0d", k), 32'(b_cnt0), (k < 3) ? 32'(k) : 32'd3);
            check($sformatf("sat_data_%0d", k), 32'(b_out_data), 32'(k));
        end
        check("sat_cnt1", 32'(b_cnt1), 32'd0);
        b_clr_cnt  = 1'b1;
        b_in0_data = 8'h77;
        #1;
        check("clr_in0_ready", 32'(b_in0_ready), 32'd1);
        tick();
        check("clr_cnt0", 32'(b_cnt0), 32'd0);
        check("clr_data", 32'(b_out_data), 32'h77);
        b_clr_cnt = 1'b0;
        tick();
        check("post_clr_cnt0", 32'(b_cnt0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
